// File: rtl/decode_stage_pipelined_if.sv
//------------------------------------------------------------------------------
// Module   : decode_stage_pipelined_if
// Brief    : Fetch, execute, writeback and status signals of the decode stage.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface decode_stage_pipelined_if #(
    parameter int INSTR_W = 32,
    parameter int REG_AW  = 6,
    parameter int OP_W    = 4,
    parameter int IMM_W   = 15,
    parameter int CNT_W   = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;

    logic               out_valid;
    logic               out_ready;
    logic               out_imm_sel;
    logic [REG_AW-1:0]  out_rs;
    logic [REG_AW-1:0]  out_rd;
    logic [OP_W-1:0]    out_aluop;
    logic [REG_AW-1:0]  out_rt;
    logic [IMM_W-1:0]   out_imm;
    logic               out_regwrite;

    logic               wb_valid;
    logic [REG_AW-1:0]  wb_rd;
    logic               flush;

    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   nop_cnt;

    // Decode stage side
    modport slave (
        input  in_valid, in_instr, out_ready, wb_valid, wb_rd, flush,
        output in_ready, out_valid, out_imm_sel, out_rs, out_rd, out_aluop,
               out_rt, out_imm, out_regwrite, stall_cnt, nop_cnt
    );

    // Fetch / execute / writeback side
    modport master (
        output in_valid, in_instr, out_ready, wb_valid, wb_rd, flush,
        input  in_ready, out_valid, out_imm_sel, out_rs, out_rd, out_aluop,
               out_rt, out_imm, out_regwrite, stall_cnt, nop_cnt
    );
endinterface

`default_nettype wire

// File: rtl/decode_stage_pipelined.sv
//------------------------------------------------------------------------------
// Module   : decode_stage_pipelined
// Brief    : Registered decode stage with operand swap, register scoreboard
//            hazard stalls, NOP bubble removal and saturating perf counters.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module decode_stage_pipelined #(
    parameter int              INSTR_W  = 32,
    parameter int              REG_AW   = 6,
    parameter int              OP_W     = 4,
    parameter int              IMM_W    = 15,
    parameter logic [OP_W-1:0] SWAP_OP0 = 4'b1011,
    parameter logic [OP_W-1:0] SWAP_OP1 = 4'b1001,
    parameter int              CNT_W    = 16
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    decode_stage_pipelined_if.slave   bus
);
    localparam int               c_nreg    = 2 ** REG_AW;
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic               w_imm_sel;
    logic [REG_AW-1:0]  w_rs_raw;
    logic [REG_AW-1:0]  w_rt_raw;
    logic [REG_AW-1:0]  w_rs;
    logic [REG_AW-1:0]  w_rt;
    logic [REG_AW-1:0]  w_rd;
    logic [OP_W-1:0]    w_aluop;
    logic [IMM_W-1:0]   w_imm;
    logic               w_swap;
    logic               w_nop;

    logic [c_nreg-1:0]  w_wb_clr;
    logic [c_nreg-1:0]  w_out_busy;
    logic [c_nreg-1:0]  w_busy;
    logic               w_hazard;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_nop_acc;
    logic               w_consume;

    logic               out_valid_q,    out_valid_d;
    logic               out_imm_sel_q,  out_imm_sel_d;
    logic [REG_AW-1:0]  out_rs_q,       out_rs_d;
    logic [REG_AW-1:0]  out_rd_q,       out_rd_d;
    logic [OP_W-1:0]    out_aluop_q,    out_aluop_d;
    logic [REG_AW-1:0]  out_rt_q,       out_rt_d;
    logic [IMM_W-1:0]   out_imm_q,      out_imm_d;
    logic               out_regwrite_q, out_regwrite_d;
    logic [c_nreg-1:0]  sb_q,           sb_d;
    logic [CNT_W-1:0]   stall_cnt_q,    stall_cnt_d;
    logic [CNT_W-1:0]   nop_cnt_q,      nop_cnt_d;

    always_comb begin
        w_imm_sel = bus.in_instr[INSTR_W-1];
        w_rs_raw  = bus.in_instr[INSTR_W-2 -: REG_AW];
        w_rd      = bus.in_instr[INSTR_W-2-REG_AW -: REG_AW];
        w_aluop   = bus.in_instr[INSTR_W-2-2*REG_AW -: OP_W];
        w_imm     = bus.in_instr[IMM_W-1:0];
        w_rt_raw  = w_imm[IMM_W-1 -: REG_AW];
        w_swap    = (w_aluop == SWAP_OP0) || (w_aluop == SWAP_OP1);
        w_rs      = w_swap ? w_rd     : w_rs_raw;
        w_rt      = w_swap ? w_rs_raw : w_rt_raw;
        w_nop     = (bus.in_instr == '0);
    end

    // A register is busy if retired-pending in the scoreboard (unless retiring
    // right now) or if it is the target of the entry sitting in the output slot.
    always_comb begin
        w_wb_clr   = '0;
        w_out_busy = '0;
        if (bus.wb_valid) begin
            w_wb_clr[bus.wb_rd] = 1'b1;
        end
        if (out_valid_q && !bus.flush) begin
            w_out_busy[out_rd_q] = 1'b1;
        end
        w_busy = (sb_q & ~w_wb_clr) | w_out_busy;
    end

    always_comb begin
        w_hazard   = !w_nop && (w_busy[w_rs] || (!w_imm_sel && w_busy[w_rt]) || w_busy[w_rd]);
        w_in_ready = !w_hazard && (!out_valid_q || bus.out_ready || bus.flush);
        w_accept   = bus.in_valid && w_in_ready && !w_nop;
        w_nop_acc  = bus.in_valid && w_in_ready && w_nop;
        w_consume  = out_valid_q && bus.out_ready && !bus.flush;
    end

    always_comb begin
        out_valid_d    = out_valid_q;
        out_imm_sel_d  = out_imm_sel_q;
        out_rs_d       = out_rs_q;
        out_rd_d       = out_rd_q;
        out_aluop_d    = out_aluop_q;
        out_rt_d       = out_rt_q;
        out_imm_d      = out_imm_q;
        out_regwrite_d = out_regwrite_q;
        stall_cnt_d    = stall_cnt_q;
        nop_cnt_d      = nop_cnt_q;

        if (w_accept) begin
            out_valid_d    = 1'b1;
            out_imm_sel_d  = w_imm_sel;
            out_rs_d       = w_rs;
            out_rd_d       = w_rd;
            out_aluop_d    = w_aluop;
            out_rt_d       = w_rt;
            out_imm_d      = w_imm;
            out_regwrite_d = 1'b1;
        end else if (bus.flush || bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        // Clear first so a same-cycle set of the same register takes priority.
        sb_d = sb_q & ~w_wb_clr;
        if (w_consume) begin
            sb_d[out_rd_q] = 1'b1;
        end

        if (bus.in_valid && !w_in_ready && (stall_cnt_q != c_cnt_max)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (w_nop_acc && (nop_cnt_q != c_cnt_max)) begin
            nop_cnt_d = nop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q    <= 1'b0;
            out_imm_sel_q  <= 1'b0;
            out_rs_q       <= '0;
            out_rd_q       <= '0;
            out_aluop_q    <= '0;
            out_rt_q       <= '0;
            out_imm_q      <= '0;
            out_regwrite_q <= 1'b0;
            sb_q           <= '0;
            stall_cnt_q    <= '0;
            nop_cnt_q      <= '0;
        end else begin
            out_valid_q    <= out_valid_d;
            out_imm_sel_q  <= out_imm_sel_d;
            out_rs_q       <= out_rs_d;
            out_rd_q       <= out_rd_d;
            out_aluop_q    <= out_aluop_d;
            out_rt_q       <= out_rt_d;
            out_imm_q      <= out_imm_d;
            out_regwrite_q <= out_regwrite_d;
            sb_q           <= sb_d;
            stall_cnt_q    <= stall_cnt_d;
            nop_cnt_q      <= nop_cnt_d;
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_imm_sel  = out_imm_sel_q;
    assign bus.out_rs       = out_rs_q;
    assign bus.out_rd       = out_rd_q;
    assign bus.out_aluop    = out_aluop_q;
    assign bus.out_rt       = out_rt_q;
    assign bus.out_imm      = out_imm_q;
    assign bus.out_regwrite = out_regwrite_q;
    assign bus.stall_cnt    = stall_cnt_q;
    assign bus.nop_cnt      = nop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage_pipelined.sv
//------------------------------------------------------------------------------
// Module   : tb_decode_stage_pipelined
// Brief    : Directed and randomized bench for decode_stage_pipelined with an
//            instruction-level reference model.
// Revision : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_decode_stage_pipelined;
    localparam int INSTR_W = 32;
    localparam int REG_AW  = 6;
    localparam int OP_W    = 4;
    localparam int IMM_W   = 15;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decode_stage_pipelined_if #(
        .INSTR_W(INSTR_W), .REG_AW(REG_AW), .OP_W(OP_W), .IMM_W(IMM_W), .CNT_W(CNT_W)
    ) bus ();

    decode_stage_pipelined #(
        .INSTR_W(INSTR_W), .REG_AW(REG_AW), .OP_W(OP_W), .IMM_W(IMM_W),
        .SWAP_OP0(4'b1011), .SWAP_OP1(4'b1001), .CNT_W(CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;
    bit rdy_seen = 1'b0;

    // Reference state: the entry in the output slot, pending writes, counters
    bit m_valid;
    int m_isel, m_rs, m_rd, m_op, m_rt, m_imm;
    bit m_sb [64];
    int m_stall, m_nop;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc(input int s, input int rs, input int rd,
                                        input int op, input int imm);
        return {s[0], rs[5:0], rd[5:0], op[3:0], imm[14:0]};
    endfunction

    // Field split by arithmetic on the word, operands already swapped
    function automatic void split(input logic [31:0] w, output int isel, output int rs,
                                  output int rd, output int op, output int rt, output int imm);
        int unsigned u;
        int rs_raw, rt_raw;
        u      = w;
        isel   = int'(u / 32'h8000_0000);
        rs_raw = int'((u >> 25) % 64);
        rd     = int'((u >> 19) % 64);
        op     = int'((u >> 15) % 16);
        imm    = int'(u % 32768);
        rt_raw = imm / 512;
        if (op == 11 || op == 9) begin
            rs = rd;
            rt = rs_raw;
        end else begin
            rs = rs_raw;
            rt = rt_raw;
        end
    endfunction

    function automatic bit busy(input int r);
        return (m_sb[r] && !(bus.wb_valid && int'(bus.wb_rd) == r)) ||
               (m_valid && !bus.flush && m_rd == r);
    endfunction

    always @(negedge clk) begin
        int isel, rs, rd, op, rt, imm;
        bit nop, haz, exp_rdy;
        if (rst) begin
            m_valid = 0; m_isel = 0; m_rs = 0; m_rd = 0; m_op = 0; m_rt = 0; m_imm = 0;
            m_stall = 0; m_nop = 0;
            for (int i = 0; i < 64; i++) m_sb[i] = 0;
        end else if (chk_en) begin
            nop = (bus.in_instr == 32'h0);
            split(bus.in_instr, isel, rs, rd, op, rt, imm);
            haz     = !nop && (busy(rs) || (isel == 0 && busy(rt)) || busy(rd));
            exp_rdy = !haz && (!m_valid || bus.out_ready || bus.flush);

            chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
            chk("out_valid", 64'(bus.out_valid), 64'(m_valid));
            if (m_valid) begin
                chk("out_imm_sel", 64'(bus.out_imm_sel), 64'(m_isel));
                chk("out_rs", 64'(bus.out_rs), 64'(m_rs));
                chk("out_rd", 64'(bus.out_rd), 64'(m_rd));
                chk("out_aluop", 64'(bus.out_aluop), 64'(m_op));
                chk("out_rt", 64'(bus.out_rt), 64'(m_rt));
                chk("out_imm", 64'(bus.out_imm), 64'(m_imm));
                chk("out_regwrite", 64'(bus.out_regwrite), 64'd1);
            end
            chk("stall_cnt", 64'(bus.stall_cnt), 64'(m_stall));
            chk("nop_cnt", 64'(bus.nop_cnt), 64'(m_nop));
            rdy_seen = bus.in_ready;

            if (bus.in_valid && !exp_rdy && m_stall < CNT_MAX) m_stall++;
            if (bus.in_valid && exp_rdy && nop && m_nop < CNT_MAX) m_nop++;
            if (bus.wb_valid) m_sb[bus.wb_rd] = 0;
            if (m_valid && bus.out_ready && !bus.flush) m_sb[m_rd] = 1;
            if (bus.in_valid && exp_rdy && !nop) begin
                m_valid = 1; m_isel = isel; m_rs = rs; m_rd = rd;
                m_op = op; m_rt = rt; m_imm = imm;
            end else if (bus.out_ready || bus.flush) begin
                m_valid = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.in_valid  = 0; bus.in_instr = '0; bus.out_ready = 0;
        bus.wb_valid  = 0; bus.wb_rd    = '0; bus.flush     = 0;
        repeat (2) @(posedge clk);
        #1;
        rst    = 0;
        chk_en = 1;

        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_stall_cnt", 64'(bus.stall_cnt), 64'd0);
        chk("rst_nop_cnt", 64'(bus.nop_cnt), 64'd0);
        chk("rst_out_fields", {bus.out_rs, bus.out_rd, bus.out_rt, bus.out_imm,
                               bus.out_aluop, bus.out_imm_sel, bus.out_regwrite}, 64'd0);

        // Plain decode, then a RAW-dependent instruction on rd=5
        step(); bus.in_valid = 1; bus.in_instr = 32'h0429_8E00; bus.out_ready = 1;
        @(negedge clk); chk("dec_in_ready", 64'(bus.in_ready), 64'd1);
        step(); bus.in_instr = 32'h0A31_8200;
        @(negedge clk);
        chk("dec_out_valid", 64'(bus.out_valid), 64'd1);
        chk("dec_rs", 64'(bus.out_rs), 64'd2);
        chk("dec_rd", 64'(bus.out_rd), 64'd5);
        chk("dec_aluop", 64'(bus.out_aluop), 64'd3);
        chk("dec_rt", 64'(bus.out_rt), 64'd7);
        chk("dec_imm", 64'(bus.out_imm), 64'h0E00);
        chk("dec_regwrite", 64'(bus.out_regwrite), 64'd1);
        chk("raw_stall_0", 64'(bus.in_ready), 64'd0);
        for (int i = 1; i < 4; i++) begin
            step(); @(negedge clk); chk("raw_stall_n", 64'(bus.in_ready), 64'd0);
        end
        step(); bus.wb_valid = 1; bus.wb_rd = 6'd5;
        @(negedge clk); chk("raw_release", 64'(bus.in_ready), 64'd1);
        step(); bus.in_valid = 0; bus.wb_valid = 0;
        @(negedge clk);
        chk("raw_stall_cnt", 64'(bus.stall_cnt), 64'd4);
        chk("raw_out_rs", 64'(bus.out_rs), 64'd5);
        chk("raw_out_rd", 64'(bus.out_rd), 64'd6);

        // Operand swap, immediately followed by three NOP words
        step(); bus.in_valid = 1; bus.in_instr = 32'h0625_8000;
        @(negedge clk); chk("swap_in_ready", 64'(bus.in_ready), 64'd1);
        step(); bus.in_instr = '0;
        @(negedge clk);
        chk("swap_rs", 64'(bus.out_rs), 64'd4);
        chk("swap_rt", 64'(bus.out_rt), 64'd3);
        chk("swap_rd", 64'(bus.out_rd), 64'd4);
        chk("swap_aluop", 64'(bus.out_aluop), 64'hB);
        repeat (2) step();
        step(); bus.in_valid = 0;
        @(negedge clk);
        chk("nop_cnt3", 64'(bus.nop_cnt), 64'd3);
        chk("nop_out_valid", 64'(bus.out_valid), 64'd0);

        // Backpressure holds the entry; flush drops it without touching rd=12
        step(); bus.in_valid = 1; bus.in_instr = enc(1, 10, 12, 2, 16'h0123);
        @(negedge clk); chk("bp_in_ready", 64'(bus.in_ready), 64'd1);
        step(); bus.in_valid = 0; bus.in_instr = '0; bus.out_ready = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_hold_rd", 64'(bus.out_rd), 64'd12);
            chk("bp_hold_imm", 64'(bus.out_imm), 64'h0123);
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
            step();
        end
        bus.flush = 1;
        @(negedge clk); chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
        step(); bus.flush = 0; bus.out_ready = 1;
        bus.in_valid = 1; bus.in_instr = enc(0, 12, 13, 0, 0);
        @(negedge clk);
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_sb_clear", 64'(bus.in_ready), 64'd1);

        // Randomized traffic on a small register window to provoke hazards
        for (int c = 0; c < 3000; c++) begin
            step();
            if (!(bus.in_valid && !rdy_seen)) begin
                bus.in_valid = ($urandom_range(0, 9) < 7);
                if ($urandom_range(0, 9) < 2) begin
                    bus.in_instr = '0;
                end else begin
                    bus.in_instr = enc(int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                                       int'($urandom_range(0, 7)),
                                       ($urandom_range(0, 3) == 0) ?
                                           (($urandom_range(0, 1) == 1) ? 11 : 9) :
                                           int'($urandom_range(0, 15)),
                                       int'(($urandom_range(0, 7) << 9) | $urandom_range(0, 511)));
                end
            end
            bus.out_ready = ($urandom_range(0, 9) < 7);
            bus.flush     = ($urandom_range(0, 19) == 0);
            bus.wb_valid  = ($urandom_range(0, 9) < 4);
            bus.wb_rd     = 6'($urandom_range(0, 7));
        end
        step();
        bus.in_valid = 0; bus.flush = 0; bus.wb_valid = 0;
        repeat (3) step();
        @(negedge clk);
        chk("stall_cnt_saturated", 64'(bus.stall_cnt), 64'(CNT_MAX));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
